hex_frame_sequencer: RTL
========================

HEX_FRAME_SEQUENCER -- requirements
Module: hex_frame_sequencer

Interface
REQ-001 Parameter N_WORDS, default 3, number of binary words per frame (>=1).
REQ-002 Parameter HEX_DIGIT_W, default 4, hex digits per word; word width WORD_W = 4*HEX_DIGIT_W.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  sample available.
REQ-006 in_ready  output  1  sequencer can capture a sample.
REQ-007 in_data  input  N_WORDS*WORD_W  packed words; word k occupies bits [k*WORD_W +: WORD_W].
REQ-008 out_valid  output  1  out_byte holds a valid ASCII character.
REQ-009 out_ready  input  1  downstream (UART TX) accepts the byte.
REQ-010 out_byte  output  8  ASCII character.
REQ-011 busy  output  1  frame in progress (state != IDLE).

Function
REQ-012 Sample SHALL be captured into an internal register on the cycle in_valid && in_ready; in_data is not used afterward.
REQ-013 in_ready SHALL be 1 only in IDLE (decoded from state register, no combinational path from in_valid).
REQ-014 Frame SHALL be: word N_WORDS-1 down to word 0, each word most-significant digit first, one 0x20 between words, then 0x0D, 0x0A.
REQ-015 Digits SHALL be uppercase: nibble 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-016 Frame length SHALL be N_WORDS*HEX_DIGIT_W + (N_WORDS-1) + 2 bytes (16 at defaults).
REQ-017 States SHALL be IDLE, DIGIT, SEP, CR, LF.
REQ-018 Transitions: IDLE->DIGIT on capture; DIGIT->SEP after last digit of a word if words remain, DIGIT->CR after last digit of word 0; SEP->DIGIT; CR->LF; LF->IDLE; each non-IDLE transition only on out_valid && out_ready.
REQ-019 out_valid and out_byte SHALL be registered; first byte valid the cycle after capture.
REQ-020 While out_valid && !out_ready, out_byte and state SHALL hold stable.
REQ-021 With out_ready held 1, one byte SHALL transfer per cycle, no bubbles within a frame.
REQ-022 After LF transfer, out_valid SHALL drop and in_ready SHALL be 1 the next cycle; no same-cycle capture during LF.
REQ-023 in_valid while not in IDLE SHALL be ignored (no capture, no effect).
REQ-024 Word and digit counters SHALL be sized $clog2 of their range (min 1 bit) and SHALL not wrap past their terminal values.
REQ-025 N_WORDS=1 SHALL produce no SEP state visit.

Reset
REQ-026 On rst: state IDLE, out_valid 0, out_byte 0x00, counters 0, captured sample 0, busy 0.
REQ-027 in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-028 rst mid-frame SHALL abort: remaining bytes discarded, out_valid 0 next cycle, no partial frame resumed.
REQ-029 rst SHALL dominate simultaneous in_valid or out_ready.

Structure
REQ-030 Package hex_frame_pkg SHALL hold the state enum and ASCII constants SPACE 0x20, CR 0x0D, LF 0x0A.
REQ-031 Digit conversion SHALL use one bin_to_ascii_hex instance with HEX_DIGIT_W = N_WORDS*HEX_DIGIT_W on the captured sample; sequencer selects the character by word/digit index.
REQ-032 No other sub-modules; RTL target 120-400 lines.

Verification
REQ-033 in_data=0x1234_ABCD_0F0F, out_ready=1 -> "1234 ABCD 0F0F\r\n", 16 consecutive valid cycles, in_ready 1 one cycle after LF.
REQ-034 Same data, out_ready random 50% -> identical byte sequence; out_byte stable across every stall cycle.
REQ-035 Second in_valid pulse (0xFFFF_FFFF_FFFF) during frame -> ignored; held in_valid captured only after LF -> "FFFF FFFF FFFF\r\n".
REQ-036 rst asserted after 5th byte transferred -> out_valid 0 next cycle, busy 0, new sample 0x0000_0000_0000 yields "0000 0000 0000\r\n" complete.
REQ-037 N_WORDS=1, HEX_DIGIT_W=2, in_data=0x9A -> "9A\r\n", 4 bytes, no 0x20.

Source files
------------

// File: rtl/hex_frame_pkg.sv
// Shared types and constants for the hex frame sequencer.
// Holds the sequencer state encoding, ASCII framing characters and the nibble-to-ASCII helper.
package hex_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIGIT = 3'd1,
    ST_SEP   = 3'd2,
    ST_CR    = 3'd3,
    ST_LF    = 3'd4
  } seq_state_e;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] NUL   = 8'h00;

  // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] chr;
    if (nib < 4'd10) begin
      chr = 8'h30 + {4'h0, nib};
    end else begin
      chr = 8'h37 + {4'h0, nib};
    end
    return chr;
  endfunction

endpackage

// File: rtl/bin_to_ascii_hex.sv
// Combinational binary-to-ASCII-hex converter.
// Digit g (nibble g of bin_i) maps to byte g of ascii_o.
module bin_to_ascii_hex
  import hex_frame_pkg::*;
#(
  parameter int HEX_DIGIT_W = 4
) (
  input  logic [4*HEX_DIGIT_W-1:0] bin_i,
  output logic [8*HEX_DIGIT_W-1:0] ascii_o
);

  for (genvar g = 0; g < HEX_DIGIT_W; g++) begin : g_digit
    assign ascii_o[8*g +: 8] = nibble_to_ascii(bin_i[4*g +: 4]);
  end

endmodule

// File: rtl/hex_frame_sequencer.sv
// Captures N_WORDS binary words and streams them as an ASCII hex line:
// words high to low, MSD first, space-separated, terminated by CR LF.
module hex_frame_sequencer
  import hex_frame_pkg::*;
#(
  parameter int N_WORDS     = 3,
  parameter int HEX_DIGIT_W = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_WORDS*4*HEX_DIGIT_W-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      out_byte,
  output logic                            busy
);

  localparam int TOTAL_DIGITS = N_WORDS * HEX_DIGIT_W;
  localparam int TOTAL_BITS   = 4 * TOTAL_DIGITS;
  localparam int WORD_CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int DIGIT_CNT_W  = (HEX_DIGIT_W > 1) ? $clog2(HEX_DIGIT_W) : 1;

  localparam logic [WORD_CNT_W-1:0]  WORD_TOP   = WORD_CNT_W'(N_WORDS - 1);
  localparam logic [WORD_CNT_W-1:0]  WORD_ZERO  = {WORD_CNT_W{1'b0}};
  localparam logic [WORD_CNT_W-1:0]  WORD_ONE   = WORD_CNT_W'(1);
  localparam logic [DIGIT_CNT_W-1:0] DIGIT_TOP  = DIGIT_CNT_W'(HEX_DIGIT_W - 1);
  localparam logic [DIGIT_CNT_W-1:0] DIGIT_ZERO = {DIGIT_CNT_W{1'b0}};
  localparam logic [DIGIT_CNT_W-1:0] DIGIT_ONE  = DIGIT_CNT_W'(1);

  seq_state_e               state_q, state_d;
  logic [WORD_CNT_W-1:0]    word_q, word_d;
  logic [DIGIT_CNT_W-1:0]   digit_q, digit_d;
  logic [TOTAL_BITS-1:0]    sample_q, sample_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_byte_q, out_byte_d;

  logic                     capture_s;
  logic                     fire_s;
  logic [8*TOTAL_DIGITS-1:0] ascii_s;
  logic [7:0]               char_tbl_s [2**WORD_CNT_W][2**DIGIT_CNT_W];

  assign capture_s = (state_q == ST_IDLE) && in_valid;
  assign fire_s    = out_valid_q && out_ready;
  assign sample_d  = capture_s ? in_data : sample_q;

  // Converting the next sample lets the first digit be registered on the capture edge.
  bin_to_ascii_hex #(
    .HEX_DIGIT_W(TOTAL_DIGITS)
  ) u_conv (
    .bin_i  (sample_d),
    .ascii_o(ascii_s)
  );

  for (genvar w = 0; w < 2**WORD_CNT_W; w++) begin : g_word
    for (genvar d = 0; d < 2**DIGIT_CNT_W; d++) begin : g_dig
      if ((w < N_WORDS) && (d < HEX_DIGIT_W)) begin : g_used
        assign char_tbl_s[w][d] = ascii_s[8*(w*HEX_DIGIT_W + d) +: 8];
      end else begin : g_pad
        assign char_tbl_s[w][d] = NUL;
      end
    end
  end

  // Next-state, counter and output-byte logic; everything holds unless a byte transfers.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    digit_d     = digit_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;

    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          state_d     = ST_DIGIT;
          word_d      = WORD_TOP;
          digit_d     = DIGIT_TOP;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_DIGIT: begin
        if (fire_s) begin
          if (digit_q != DIGIT_ZERO) begin
            digit_d = digit_q - DIGIT_ONE;
          end else if (word_q != WORD_ZERO) begin
            state_d = ST_SEP;
          end else begin
            state_d = ST_CR;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_SEP: begin
        if (fire_s) begin
          state_d = ST_DIGIT;
          word_d  = word_q - WORD_ONE;
          digit_d = DIGIT_TOP;
        end else begin
          state_d = state_q;
        end
      end
      ST_CR: begin
        if (fire_s) begin
          state_d = ST_LF;
        end else begin
          state_d = state_q;
        end
      end
      ST_LF: begin
        if (fire_s) begin
          state_d     = ST_IDLE;
          word_d      = WORD_ZERO;
          digit_d     = DIGIT_ZERO;
          out_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        word_d      = WORD_ZERO;
        digit_d     = DIGIT_ZERO;
        out_valid_d = 1'b0;
      end
    endcase

    case (state_d)
      ST_DIGIT: out_byte_d = char_tbl_s[word_d][digit_d];
      ST_SEP:   out_byte_d = SPACE;
      ST_CR:    out_byte_d = CR;
      ST_LF:    out_byte_d = LF;
      default:  out_byte_d = NUL;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= WORD_ZERO;
      digit_q     <= DIGIT_ZERO;
      sample_q    <= {TOTAL_BITS{1'b0}};
      out_valid_q <= 1'b0;
      out_byte_q  <= NUL;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      digit_q     <= digit_d;
      sample_q    <= sample_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;

endmodule
